cook_sequencer: RTL

COOK_SEQUENCER -- requirements
Module: cook_sequencer

---
 rtl/cook_sequencer_if.sv | 28 ++
 rtl/cook_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cook_sequencer_if.sv
// rtl/cook_sequencer_if.sv - Panel, keypad and display signal bundle for the cook sequencer
interface cook_sequencer_if;
    logic       tick_1hz;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door_closed;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       mag_on;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       timer_done;
    logic       beep;
    logic [1:0] state;

    modport master (
        output tick_1hz, startn, stopn, clearn, door_closed, key_valid, key_digit,
        input  mag_on, min_tens, min_ones, sec_tens, sec_ones, timer_done, beep, state
    );

    modport slave (
        input  tick_1hz, startn, stopn, clearn, door_closed, key_valid, key_digit,
        output mag_on, min_tens, min_ones, sec_tens, sec_ones, timer_done, beep, state
    );
endinterface

// File: rtl/cook_sequencer.sv
// rtl/cook_sequencer.sv - Microwave cook sequencer: keypad entry, BCD countdown, pause and alert
module cook_sequencer (
    input  logic           clk,
    input  logic           resetn,
    cook_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COOKING = 2'b01,
        PAUSED  = 2'b10,
        DONE    = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] mt_q, mo_q, st_q, so_q;
    logic [3:0] mt_d, mo_d, st_d, so_d;
    logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
    logic       mag_q, mag_d;
    logic       done_q, done_d;
    logic       beep_q, beep_d;
    logic [1:0] ticks_q, ticks_d;
    logic       startn_q, stopn_q, clearn_q;
    logic       armed_q;
    logic       start_press, stop_press, clear_press;
    logic       time_zero, time_one;

    // The first edge after reset only loads button history, so a button held
    // through reset release is never seen as a fresh press.
    assign start_press = armed_q & startn_q & ~bus.startn;
    assign stop_press  = armed_q & stopn_q  & ~bus.stopn;
    assign clear_press = armed_q & clearn_q & ~bus.clearn;

    assign time_zero = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
    assign time_one  = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd1);

    // One-second BCD decrement; seconds tens above 5 simply count down as entered.
    always_comb begin
        dec_mt = mt_q;
        dec_mo = mo_q;
        dec_st = st_q;
        dec_so = so_q;
        if (so_q != 4'd0) begin
            dec_so = so_q - 4'd1;
        end else if (st_q != 4'd0) begin
            dec_so = 4'd9;
            dec_st = st_q - 4'd1;
        end else begin
            dec_so = 4'd9;
            dec_st = 4'd5;
            if (mo_q != 4'd0) begin
                dec_mo = mo_q - 4'd1;
            end else begin
                dec_mo = 4'd9;
                dec_mt = mt_q - 4'd1;
            end
        end
    end

    // Next state, next time digits and next registered outputs.
    always_comb begin
        state_d = state_q;
        mt_d    = mt_q;
        mo_d    = mo_q;
        st_d    = st_q;
        so_d    = so_q;
        done_d  = 1'b0;
        ticks_d = ticks_q;
        case (state_q)
            IDLE: begin
                if (clear_press) begin
                    {mt_d, mo_d, st_d, so_d} = 16'h0000;
                end else if (start_press && bus.door_closed && !time_zero) begin
                    state_d = COOKING;
                end else if (bus.key_valid && (bus.key_digit <= 4'd9)) begin
                    mt_d = mo_q;
                    mo_d = st_q;
                    st_d = so_q;
                    so_d = bus.key_digit;
                end
            end
            COOKING: begin
                if (clear_press) begin
                    state_d = IDLE;
                    {mt_d, mo_d, st_d, so_d} = 16'h0000;
                end else if (!bus.door_closed || stop_press) begin
                    state_d = PAUSED;
                end else if (bus.tick_1hz) begin
                    {mt_d, mo_d, st_d, so_d} = {dec_mt, dec_mo, dec_st, dec_so};
                    if (time_one) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        ticks_d = 2'd0;
                    end
                end
            end
            PAUSED: begin
                if (clear_press || stop_press) begin
                    state_d = IDLE;
                    {mt_d, mo_d, st_d, so_d} = 16'h0000;
                end else if (start_press && bus.door_closed) begin
                    state_d = COOKING;
                end
            end
            DONE: begin
                if (start_press || stop_press || clear_press) begin
                    state_d = IDLE;
                    ticks_d = 2'd0;
                end else if (bus.tick_1hz) begin
                    if (ticks_q == 2'd2) begin
                        state_d = IDLE;
                        ticks_d = 2'd0;
                    end else begin
                        ticks_d = ticks_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        mag_d  = (state_d == COOKING);
        beep_d = (state_d == DONE);
    end

    // State, time, outputs and button history registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            mt_q     <= 4'd0;
            mo_q     <= 4'd0;
            st_q     <= 4'd0;
            so_q     <= 4'd0;
            mag_q    <= 1'b0;
            done_q   <= 1'b0;
            beep_q   <= 1'b0;
            ticks_q  <= 2'd0;
            startn_q <= 1'b1;
            stopn_q  <= 1'b1;
            clearn_q <= 1'b1;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mt_q     <= mt_d;
            mo_q     <= mo_d;
            st_q     <= st_d;
            so_q     <= so_d;
            mag_q    <= mag_d;
            done_q   <= done_d;
            beep_q   <= beep_d;
            ticks_q  <= ticks_d;
            startn_q <= bus.startn;
            stopn_q  <= bus.stopn;
            clearn_q <= bus.clearn;
            armed_q  <= 1'b1;
        end
    end

    assign bus.mag_on     = mag_q;
    assign bus.timer_done = done_q;
    assign bus.beep       = beep_q;
    assign bus.state      = state_q;
    assign bus.min_tens   = mt_q;
    assign bus.min_ones   = mo_q;
    assign bus.sec_tens   = st_q;
    assign bus.sec_ones   = so_q;
endmodule
